// File: rtl/axi_sched_pkg.sv
// Shared types and defaults for the AXI transaction scheduler.
// Latency: n/a (types only). Backpressure: n/a.
package axi_sched_pkg;

  localparam int TID_WID_DEF   = 4;
  localparam int MAX_OUTST_DEF = 4;
  localparam int CNT_WID       = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } sched_state_t;

  typedef enum logic {
    DIR_WR = 1'b0,
    DIR_RD = 1'b1
  } sched_dir_t;

endpackage

// File: rtl/axi_sched_outst_cnt.sv
// Outstanding-transaction counter: up on issue, down on completion, sticky underflow flag.
// Latency: count visible the cycle after inc/dec. Backpressure: none; saturates at MAX and 0.
module axi_sched_outst_cnt
  import axi_sched_pkg::*;
#(
  parameter int MAX = MAX_OUTST_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  input  logic               dec,
  output logic [CNT_WID-1:0] cnt,
  output logic               err
);

  localparam logic [CNT_WID-1:0] MAX_C = CNT_WID'(MAX);

  // Simultaneous inc and dec cancel, so only the lone cases move the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      case ({inc, dec})
        2'b10: begin
          if (cnt != MAX_C) cnt <= cnt + 1'b1;
        end
        2'b01: begin
          if (cnt == '0) err <= 1'b1;
          else           cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/axi_txn_scheduler.sv
// Grants one write or read transaction at a time (IDLE->GRANT->GAP), limits outstanding per direction.
// Latency: grant 1 cycle after an eligible request in IDLE, min issue interval 3. Backpressure: a direction
// at MAX_OUTST is held off; AXI_SCHED_FIXED_PRIO_EN makes write win ties instead of round-robin.
module axi_txn_scheduler
  import axi_sched_pkg::*;
#(
  parameter int TID_WID   = TID_WID_DEF,
  parameter int MAX_OUTST = MAX_OUTST_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_req,
  input  logic               rd_req,
  output logic               wr_gnt,
  output logic               rd_gnt,
  output logic               wr_trn_en,
  output logic               rd_trn_en,
  input  logic               wr_rsp_en,
  input  logic               rd_rsp_en,
  input  logic               rlast,
  output logic [CNT_WID-1:0] wr_outst,
  output logic [CNT_WID-1:0] rd_outst,
  output logic               busy,
  output logic               err_unexp
);

  generate
    if (TID_WID < 1 || MAX_OUTST < 1 || MAX_OUTST > 15) begin : g_bad_cfg
      $error("axi_txn_scheduler: TID_WID must be >= 1 and MAX_OUTST in 1..15");
    end
  endgenerate

  localparam logic [CNT_WID-1:0] MAX_C = CNT_WID'(MAX_OUTST);

  sched_state_t state;
  logic         wr_elig;
  logic         rd_elig;
  logic         pick_wr;
  logic         wr_err;
  logic         rd_err;
  logic         rd_done;

  assign wr_elig = wr_req && (wr_outst < MAX_C);
  assign rd_elig = rd_req && (rd_outst < MAX_C);
  assign rd_done = rd_rsp_en && rlast;

`ifdef AXI_SCHED_FIXED_PRIO_EN
  assign pick_wr = wr_elig;
`else
  sched_dir_t last_dir;

  // On a tie the direction not served last goes next.
  assign pick_wr = wr_elig && (!rd_elig || (last_dir == DIR_RD));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      wr_gnt    <= 1'b0;
      rd_gnt    <= 1'b0;
      wr_trn_en <= 1'b0;
      rd_trn_en <= 1'b0;
`ifndef AXI_SCHED_FIXED_PRIO_EN
      last_dir  <= DIR_RD;
`endif
    end else begin
      wr_gnt    <= 1'b0;
      rd_gnt    <= 1'b0;
      wr_trn_en <= 1'b0;
      rd_trn_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (wr_elig || rd_elig) begin
            state     <= ST_GRANT;
            wr_gnt    <= pick_wr;
            wr_trn_en <= pick_wr;
            rd_gnt    <= !pick_wr;
            rd_trn_en <= !pick_wr;
`ifndef AXI_SCHED_FIXED_PRIO_EN
            last_dir  <= pick_wr ? DIR_WR : DIR_RD;
`endif
          end
        end
        ST_GRANT: state <= ST_GAP;
        ST_GAP:   state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  axi_sched_outst_cnt #(.MAX(MAX_OUTST)) u_wr_cnt (
    .clk (clk),
    .rst (rst),
    .inc (wr_trn_en),
    .dec (wr_rsp_en),
    .cnt (wr_outst),
    .err (wr_err)
  );

  axi_sched_outst_cnt #(.MAX(MAX_OUTST)) u_rd_cnt (
    .clk (clk),
    .rst (rst),
    .inc (rd_trn_en),
    .dec (rd_done),
    .cnt (rd_outst),
    .err (rd_err)
  );

  assign err_unexp = wr_err || rd_err;
  assign busy      = (wr_outst != '0) || (rd_outst != '0) || (state != ST_IDLE);

endmodule
